axi4_lite_regfile: RTL and testbench
====================================

Name: axi4_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file; next generation of the team's single-FSM AXI4-Lite slave memory.
- Read and write paths are independent and run concurrently.
- AW and W are accepted in either order or together.
- Byte addresses are decoded against a base address; out-of-range accesses return SLVERR.
- Sits behind the interconnect as the generic control/status register bank.

Parameters:
ADDRESS_WIDTH, 32, width of AWADDR/ARADDR (byte address).
DATA_WIDTH, 32, data bus width; legal values 32 or 64.
DATA_DEPTH, 32, number of words; power of 2, at least 2.
BASE_ADDR, 0, byte address of word 0; aligned to DATA_DEPTH*DATA_WIDTH/8.

Ports:
ACLK  input  1  clock; all logic on rising edge.
ARESET  input  1  asynchronous, active-high reset.
S_AXI_AWADDR  input  ADDRESS_WIDTH  write byte address.
S_AXI_AWVALID  input  1  write address valid.
S_AXI_AWREADY  output  1  write address ready.
S_AXI_WDATA  input  DATA_WIDTH  write data.
S_AXI_WSTRB  input  DATA_WIDTH/8  byte enables.
S_AXI_WVALID  input  1  write data valid.
S_AXI_WREADY  output  1  write data ready.
S_AXI_BRESP  output  2  write response.
S_AXI_BVALID  output  1  write response valid.
S_AXI_BREADY  input  1  write response ready.
S_AXI_ARADDR  input  ADDRESS_WIDTH  read byte address.
S_AXI_ARVALID  input  1  read address valid.
S_AXI_ARREADY  output  1  read address ready.
S_AXI_RDATA  output  DATA_WIDTH  read data.
S_AXI_RRESP  output  2  read response.
S_AXI_RVALID  output  1  read data valid.
S_AXI_RREADY  input  1  read data ready.

Behaviour:
Reset
- ARESET high, asynchronous: all mem words 0; AW/W holding slots empty.
- All outputs 0: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
- First cycle after release: AWREADY=WREADY=ARREADY=1.
- Reset mid-transaction aborts it: no partial write, no response.

Address decode
- off = addr - BASE_ADDR; index = off >> log2(DATA_WIDTH/8).
- Low byte-offset bits are ignored (misaligned addresses map to the containing word).
- in_range = (addr >= BASE_ADDR) && (index < DATA_DEPTH). Compare at full ADDRESS_WIDTH; no wrap.

Write path (states WR_COLLECT, WR_RESP)
- WR_COLLECT:
  - AWREADY = !aw_full; WREADY = !w_full.
  - A handshake loads its holding slot.
  - aw_have = aw_full | AW handshake; w_have = w_full | W handshake.
  - When aw_have && w_have: at that edge, commit bytes whose WSTRB bit is set (held or incoming values, bypass mux), clear both slots, BVALID<=1, go to WR_RESP.
  - Latency: BVALID 1 cycle after the later of the two handshakes.
- WR_RESP: AWREADY=WREADY=0. BVALID held with BRESP stable until BREADY; then return to WR_COLLECT.
- BRESP = 2'b00 (OKAY) when in range; 2'b10 (SLVERR) otherwise, with mem untouched.
- WSTRB=0 is a legal no-op write with an OKAY response.

Read path (states RD_IDLE, RD_DATA)
- RD_IDLE: ARREADY=1. On handshake: RDATA <= mem[index] (0 if out of range); RRESP <= OKAY/SLVERR; RVALID<=1; go to RD_DATA.
- RD_DATA: ARREADY=0. RDATA/RRESP held stable until RREADY; then RVALID<=0, go to RD_IDLE.
- Throughput: at most 1 read per 2 cycles.

Concurrency
- Read and write of the same word on the same edge: read returns the pre-write value.
- Write commit has no priority over a read; the two paths never stall each other.

Optional Feature:
AXIL_RD_PIPE_EN
- Defined: one extra register stage on read data for timing. RVALID rises 2 cycles after the AR handshake. RDATA samples mem on the edge after the handshake, so a write committing on the handshake edge is visible.
- Undefined: 1-cycle read latency as described above.

Decomposition:
- Package axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; write/read state encodings; a clog2 function for index width.
- Sub-module axi4_lite_wr_join: AW/W holding slots, ready generation, and aw_have/w_have join logic.
- Decode and memory stay in the top level.

Test Plan:
- Reset then AW 0x08 and W 0xDEADBEEF/STRB 0xF in the same cycle -> BVALID next cycle with BRESP=00; read 0x08 -> RDATA=0xDEADBEEF, RRESP=00, RVALID 1 cycle after AR handshake (2 with AXIL_RD_PIPE_EN).
- W 0x11223344 issued 3 cycles before AW 0x04 -> WREADY drops after W, write commits on AW; then STRB 0x5 with 0xAABBCCDD -> read 0x04 = 0x11BB33DD.
- Write to 0x80 with DATA_DEPTH=32, BASE_ADDR=0 -> BRESP=10, mem unchanged; read 0x80 -> RDATA=0, RRESP=10.
- BREADY held low 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout; RREADY low 5 cycles -> RDATA/RRESP stable, ARREADY=0.
- Concurrent write of 0x55 to 0x0C and read of 0x0C on the same edge (old value 0) -> RDATA=0, subsequent read = 0x55.
- Assert ARESET asynchronously mid-WR_RESP -> BVALID drops immediately, all mem reads 0 afterwards, first post-reset cycle has all READYs=1.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite register file: response codes, write and
// read state encodings, and a constant clog2 helper used to size the word index.
// No ports.
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_e;

  // RD_WAIT is only reachable when the read data pipeline stage is enabled.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_if.sv
// -----------------------------------------------------------------------------
// axi4_lite_regfile_if
// AXI4-Lite bus bundle (AW, W, B, AR, R channels) for the register file.
//   slave  modport : used by axi4_lite_regfile
//   master modport : used by whatever drives the bus (interconnect, bench)
// Parameters: ADDRESS_WIDTH (byte address width), DATA_WIDTH (32 or 64).
// -----------------------------------------------------------------------------
interface axi4_lite_regfile_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axi4_lite_wr_join.sv
// -----------------------------------------------------------------------------
// axi4_lite_wr_join
// Joins the AW and W channels, which may arrive in either order or together.
// Each channel has a one-entry holding slot; a channel's READY is high while the
// write path is collecting and its slot is empty. o_commit fires on the edge at
// which both an address and data are available (held or arriving), and the
// o_addr/o_data/o_strb outputs bypass the slot when the value arrives that cycle.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   i_collect             : write path is in its collecting state (and not in reset)
//   i_aw*/i_w*            : incoming AW / W channel signals
//   o_awready, o_wready   : channel ready outputs
//   o_commit              : write commits at the coming edge
//   o_addr/o_data/o_strb  : effective write address / data / byte enables
// -----------------------------------------------------------------------------
module axi4_lite_wr_join #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_collect,
  input  logic [ADDRESS_WIDTH-1:0]  i_awaddr,
  input  logic                      i_awvalid,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                      i_wvalid,
  output logic                      o_awready,
  output logic                      o_wready,
  output logic                      o_commit,
  output logic [ADDRESS_WIDTH-1:0]  o_addr,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic [DATA_WIDTH/8-1:0]   o_strb
);

  logic                      r_aw_full;
  logic [ADDRESS_WIDTH-1:0]  r_aw_addr;
  logic                      r_w_full;
  logic [DATA_WIDTH-1:0]     r_w_data;
  logic [DATA_WIDTH/8-1:0]   r_w_strb;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_have;
  logic w_w_have;

  assign o_awready = i_collect && !r_aw_full;
  assign o_wready  = i_collect && !r_w_full;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;
  assign w_aw_have = r_aw_full || w_aw_hs;
  assign w_w_have  = r_w_full || w_w_hs;
  assign o_commit  = i_collect && w_aw_have && w_w_have;

  assign o_addr = r_aw_full ? r_aw_addr : i_awaddr;
  assign o_data = r_w_full  ? r_w_data  : i_wdata;
  assign o_strb = r_w_full  ? r_w_strb  : i_wstrb;

  // NOTE: clocked state uses non-blocking (<=) assignments so every flop samples
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else if (o_commit) begin
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= i_awaddr;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= i_wdata;
        r_w_strb <= i_wstrb;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi4_lite_regfile
// AXI4-Lite slave register file with independent, concurrent read and write
// paths. Byte addresses are decoded against BASE_ADDR; accesses outside the
// DATA_DEPTH-word window get SLVERR (writes are dropped, reads return 0).
// Ports:
//   ACLK   : clock, rising edge
//   ARESET : asynchronous active-high reset (clears memory and all outputs)
//   s_axi  : AXI4-Lite slave bus (axi4_lite_regfile_if.slave)
// Build option:
//   AXIL_RD_PIPE_EN : adds a register stage on read data; RVALID rises two
//                     cycles after the AR handshake and memory is sampled on
//                     the edge after the handshake.
// -----------------------------------------------------------------------------
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic                ACLK,
  input logic                ARESET,
  axi4_lite_regfile_if.slave s_axi
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = clog2(STRB_W);
  localparam int IDX_W      = clog2(DATA_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DATA_DEPTH);

  // The extra top bit of the offset is the borrow: set when addr < BASE_ADDR.
  function automatic logic addr_in_range(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !off[ADDRESS_WIDTH] && ((off[ADDRESS_WIDTH-1:0] >> BYTE_SHIFT) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [ADDRESS_WIDTH-1:0] word;
    word = (addr - BASE_ADDR) >> BYTE_SHIFT;
    return word[IDX_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];

  // ---------------------------------------------------------------- write path
  wr_state_e r_wr_state;
  wr_state_e w_wr_next;
  logic      w_wr_collect;
  logic      w_bvalid;
  logic      w_wr_commit;
  logic [ADDRESS_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]    w_wr_data;
  logic [STRB_W-1:0]        w_wr_strb;
  logic                     w_wr_ok;
  logic [IDX_W-1:0]         w_wr_idx;
  logic [1:0]               r_bresp;

  axi4_lite_wr_join #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_wr_join (
    .clk       (ACLK),
    .rst       (ARESET),
    .i_collect (w_wr_collect),
    .i_awaddr  (s_axi.S_AXI_AWADDR),
    .i_awvalid (s_axi.S_AXI_AWVALID),
    .i_wdata   (s_axi.S_AXI_WDATA),
    .i_wstrb   (s_axi.S_AXI_WSTRB),
    .i_wvalid  (s_axi.S_AXI_WVALID),
    .o_awready (s_axi.S_AXI_AWREADY),
    .o_wready  (s_axi.S_AXI_WREADY),
    .o_commit  (w_wr_commit),
    .o_addr    (w_wr_addr),
    .o_data    (w_wr_data),
    .o_strb    (w_wr_strb)
  );

  assign w_wr_ok  = addr_in_range(w_wr_addr);
  assign w_wr_idx = addr_index(w_wr_addr);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_wr_state <= WR_COLLECT;
    else        r_wr_state <= w_wr_next;
  end

  // NOTE: every combinational output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_COLLECT: if (w_wr_commit)          w_wr_next = WR_RESP;
      WR_RESP:    if (s_axi.S_AXI_BREADY)   w_wr_next = WR_COLLECT;
      default:                              w_wr_next = WR_COLLECT;
    endcase
  end

  // Readies are held low while reset is asserted, so every output reads 0.
  always_comb begin
    w_wr_collect = 1'b0;
    w_bvalid     = 1'b0;
    case (r_wr_state)
      WR_COLLECT: w_wr_collect = !ARESET;
      WR_RESP:    w_bvalid     = 1'b1;
      default:    ;
    endcase
  end

  // NOTE: the register array is reset with everything else because software
  // relies on all registers reading 0 after reset; this keeps it in flops.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < DATA_DEPTH; i++) r_mem[i] <= '0;
      r_bresp <= RESP_OKAY;
    end else if (w_wr_commit) begin
      r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      if (w_wr_ok) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (w_wr_strb[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

  assign s_axi.S_AXI_BVALID = w_bvalid;
  assign s_axi.S_AXI_BRESP  = r_bresp;

  // ----------------------------------------------------------------- read path
  rd_state_e             r_rd_state;
  rd_state_e             w_rd_next;
  logic                  w_arready;
  logic                  w_rvalid;
  logic                  w_ar_hs;
  logic                  w_rd_ok;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  assign w_ar_hs  = s_axi.S_AXI_ARVALID && w_arready;
  assign w_rd_ok  = addr_in_range(s_axi.S_AXI_ARADDR);
  assign w_rd_idx = addr_index(s_axi.S_AXI_ARADDR);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_rd_state <= RD_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
`ifdef AXIL_RD_PIPE_EN
      RD_IDLE: if (w_ar_hs)             w_rd_next = RD_WAIT;
`else
      RD_IDLE: if (w_ar_hs)             w_rd_next = RD_DATA;
`endif
      RD_WAIT:                          w_rd_next = RD_DATA;
      RD_DATA: if (s_axi.S_AXI_RREADY)  w_rd_next = RD_IDLE;
      default:                          w_rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rd_state)
      RD_IDLE: w_arready = !ARESET;
      RD_DATA: w_rvalid  = 1'b1;
      default: ;
    endcase
  end

`ifdef AXIL_RD_PIPE_EN
  logic             r_rd_ok;
  logic [IDX_W-1:0] r_rd_idx;

  // Address is captured at the handshake; memory is sampled one edge later so
  // a write committing on the handshake edge is already visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rd_ok  <= 1'b0;
      r_rd_idx <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rd_ok  <= w_rd_ok;
        r_rd_idx <= w_rd_idx;
      end
      if (r_rd_state == RD_WAIT) begin
        r_rdata <= r_rd_ok ? r_mem[r_rd_idx] : '0;
        r_rresp <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end
`else
  // Sampling at the handshake edge returns the pre-write value when a write to
  // the same word commits on that edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
      r_rresp <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end
`endif

  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = w_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_regfile
// Self-checking bench for axi4_lite_regfile (default parameters: 32-bit data,
// 32 words, base address 0). Expected values come from a word-array model of
// the register file updated with byte-enable arithmetic. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_lite_regfile;

  localparam int DEPTH = 32;
`ifdef AXIL_RD_PIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [31:0] exp_mem [DEPTH];

  axi4_lite_regfile_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_regfile #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .DATA_DEPTH    (DEPTH),
    .BASE_ADDR     (32'h0)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s_axi  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------------ model
  function automatic bit model_in_range(input logic [31:0] addr);
    return addr < 32'd128;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    if (model_in_range(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) exp_mem[addr[6:2]][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    return model_in_range(addr) ? exp_mem[addr[6:2]] : 32'h0;
  endfunction

  // ------------------------------------------------------------- bus driving
  task automatic clear_inputs();
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // hold_ok: the channel already accepted keeps its READY low while waiting for
  // the other, and B stays valid/stable with both READYs low during b_hold.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_hold, output logic [1:0] resp, output int lat,
                           output bit hold_ok, output bit to);
    bit aw_done, w_done, aw_hs, w_hs;
    int c;
    aw_done = 0; w_done = 0; hold_ok = 1; to = 0; c = 0; lat = 0; resp = 2'bxx;
    @(negedge clk);
    while (!(aw_done && w_done)) begin
      if (c > 60) begin to = 1; break; end
      if (w_done && !aw_done && bus.S_AXI_WREADY) hold_ok = 0;
      if (aw_done && !w_done && bus.S_AXI_AWREADY) hold_ok = 0;
      bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = !aw_done && (c >= aw_dly);
      bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb;
      bus.S_AXI_WVALID = !w_done && (c >= w_dly);
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      @(negedge clk);
      c++;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    if (!to) begin
      lat = 1;
      while (!bus.S_AXI_BVALID && lat < 50) begin @(negedge clk); lat++; end
      if (!bus.S_AXI_BVALID) to = 1;
      resp = bus.S_AXI_BRESP;
      repeat (b_hold) begin
        @(negedge clk);
        if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP !== resp ||
            bus.S_AXI_AWREADY || bus.S_AXI_WREADY) hold_ok = 0;
      end
      bus.S_AXI_BREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_hold,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output bit hold_ok, output bit to);
    int n;
    hold_ok = 1; to = 0; lat = 0; n = 0; data = 'x; resp = 2'bxx;
    @(negedge clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_ARREADY) begin
      to = 1; bus.S_AXI_ARVALID = 1'b0;
    end else begin
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      lat = 1;
      while (!bus.S_AXI_RVALID && lat < 50) begin @(negedge clk); lat++; end
      if (!bus.S_AXI_RVALID) to = 1;
      data = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
      repeat (r_hold) begin
        @(negedge clk);
        if (!bus.S_AXI_RVALID || bus.S_AXI_RDATA !== data ||
            bus.S_AXI_RRESP !== resp || bus.S_AXI_ARREADY) hold_ok = 0;
      end
      bus.S_AXI_RREADY = 1'b1;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [6:0] flags;
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    #12;
    flags = {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
             bus.S_AXI_RVALID, bus.S_AXI_BRESP[1], bus.S_AXI_RRESP[1]};
    checks++;
    if (flags !== 7'b0 || bus.S_AXI_BRESP !== 2'b00 || bus.S_AXI_RRESP !== 2'b00) begin
      failures++; $display("FAIL reset outputs: got %b expected 0000000", flags);
    end
    checks++;
    if (bus.S_AXI_RDATA !== 32'h0) begin
      failures++; $display("FAIL reset rdata: got %h expected 00000000", bus.S_AXI_RDATA);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 3'b111) begin
      failures++;
      $display("FAIL reset readies: got %b expected 111",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp; logic [31:0] data; int lat; bit ok, to;
    axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, lat, ok, to);
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    checks++;
    if (to || resp !== 2'b00 || lat != 1) begin
      failures++; $display("FAIL same_cycle write: resp=%b lat=%0d to=%0d expected resp=00 lat=1", resp, lat, to);
    end
    axi_read(32'h08, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'hDEADBEEF || resp !== 2'b00) begin
      failures++; $display("FAIL same_cycle read: got %h/%b expected deadbeef/00", data, resp);
    end
    checks++;
    if (lat != RD_LAT) begin
      failures++; $display("FAIL read latency: got %0d expected %0d", lat, RD_LAT);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp; logic [31:0] data; int lat; bit ok, to;
    axi_write(32'h04, 32'h11223344, 4'hF, 3, 0, 0, resp, lat, ok, to);
    model_write(32'h04, 32'h11223344, 4'hF);
    checks++;
    if (to || !ok || resp !== 2'b00 || lat != 1) begin
      failures++; $display("FAIL w_first write: resp=%b lat=%0d hold_ok=%0d to=%0d expected 00/1/1/0", resp, lat, ok, to);
    end
    axi_write(32'h04, 32'hAABBCCDD, 4'h5, 0, 0, 0, resp, lat, ok, to);
    model_write(32'h04, 32'hAABBCCDD, 4'h5);
    axi_read(32'h04, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'h11BB33DD || resp !== 2'b00) begin
      failures++; $display("FAIL strobe merge: got %h/%b expected 11bb33dd/00", data, resp);
    end
    axi_write(32'h18, 32'h0BADF00D, 4'hF, 0, 2, 0, resp, lat, ok, to);
    model_write(32'h18, 32'h0BADF00D, 4'hF);
    checks++;
    if (to || !ok || resp !== 2'b00 || lat != 1) begin
      failures++; $display("FAIL aw_first write: resp=%b lat=%0d hold_ok=%0d to=%0d expected 00/1/1/0", resp, lat, ok, to);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] data; int lat; bit ok, to;
    axi_write(32'h80, 32'h12345678, 4'hF, 0, 0, 0, resp, lat, ok, to);
    checks++;
    if (to || resp !== 2'b10) begin
      failures++; $display("FAIL oor write bresp: got %b expected 10", resp);
    end
    axi_read(32'h80, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'h0 || resp !== 2'b10) begin
      failures++; $display("FAIL oor read: got %h/%b expected 00000000/10", data, resp);
    end
    axi_read(32'h00, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'h0 || resp !== 2'b00) begin
      failures++; $display("FAIL word0 after oor write: got %h/%b expected 00000000/00", data, resp);
    end
    axi_write(32'h7E, 32'hFEEDFACE, 4'hF, 1, 0, 0, resp, lat, ok, to);
    model_write(32'h7E, 32'hFEEDFACE, 4'hF);
    axi_read(32'h7C, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'hFEEDFACE || resp !== 2'b00) begin
      failures++; $display("FAIL last word misaligned: got %h/%b expected feedface/00", data, resp);
    end
    axi_write(32'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 0, resp, lat, ok, to);
    checks++;
    if (to || resp !== 2'b00) begin
      failures++; $display("FAIL strb0 bresp: got %b expected 00", resp);
    end
    axi_read(32'h08, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL strb0 no-op: got %h expected deadbeef", data);
    end
  endtask

  task automatic test_stalls();
    logic [1:0] resp; logic [31:0] data; int lat; bit ok, to;
    axi_write(32'h10, 32'h5A5A0F0F, 4'hF, 0, 0, 5, resp, lat, ok, to);
    model_write(32'h10, 32'h5A5A0F0F, 4'hF);
    checks++;
    if (to || !ok || resp !== 2'b00) begin
      failures++; $display("FAIL bready stall: hold_ok=%0d resp=%b to=%0d expected 1/00/0", ok, resp, to);
    end
    axi_read(32'h10, 5, data, resp, lat, ok, to);
    checks++;
    if (to || !ok || data !== 32'h5A5A0F0F || resp !== 2'b00) begin
      failures++; $display("FAIL rready stall: hold_ok=%0d data=%h resp=%b expected 1/5a5a0f0f/00", ok, data, resp);
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] resp; logic [31:0] data, old_val, exp_val; int lat, n; bit ok, to;
    @(negedge clk);
    old_val = exp_mem[3];
    bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h55; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 32'h0C; bus.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    model_write(32'h0C, 32'h55, 4'hF);
`ifdef AXIL_RD_PIPE_EN
    exp_val = exp_mem[3];
`else
    exp_val = old_val;
`endif
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1 || bus.S_AXI_BRESP !== 2'b00) begin
      failures++; $display("FAIL concurrent bvalid/bresp: got %b/%b expected 1/00", bus.S_AXI_BVALID, bus.S_AXI_BRESP);
    end
    n = 1;
    while (!bus.S_AXI_RVALID && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (bus.S_AXI_RVALID !== 1'b1 || bus.S_AXI_RDATA !== exp_val || bus.S_AXI_RRESP !== 2'b00) begin
      failures++; $display("FAIL concurrent read: got %h (rvalid=%b) expected %h", bus.S_AXI_RDATA, bus.S_AXI_RVALID, exp_val);
    end
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    axi_read(32'h0C, 0, data, resp, lat, ok, to);
    checks++;
    if (to || data !== 32'h55) begin
      failures++; $display("FAIL concurrent follow-up read: got %h expected 00000055", data);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, rdata, exp_data;
    logic [3:0]  strb;
    logic [1:0]  resp, exp_resp;
    int lat, d1, d2, hold; bit ok, to;
    for (int i = 0; i < 60; i++) begin
      addr = $urandom_range(0, 143);
      data = $urandom;
      strb = 4'($urandom_range(0, 15));
      d1 = $urandom_range(0, 3); d2 = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      exp_resp = model_in_range(addr) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 1) begin
        axi_write(addr, data, strb, d1, d2, hold, resp, lat, ok, to);
        model_write(addr, data, strb);
        checks++;
        if (to || !ok || lat != 1 || resp !== exp_resp) begin
          failures++;
          $display("FAIL rand write %0d addr=%h: resp=%b lat=%0d hold_ok=%0d to=%0d expected resp=%b lat=1", i, addr, resp, lat, ok, to, exp_resp);
        end
      end else begin
        exp_data = model_read(addr);
        axi_read(addr, hold, rdata, resp, lat, ok, to);
        checks++;
        if (to || !ok || lat != RD_LAT || rdata !== exp_data || resp !== exp_resp) begin
          failures++;
          $display("FAIL rand read %0d addr=%h: got %h/%b lat=%0d hold_ok=%0d expected %h/%b lat=%0d", i, addr, rdata, resp, lat, ok, exp_data, exp_resp, RD_LAT);
        end
      end
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [1:0] resp; logic [31:0] data; int lat; bit ok, to;
    @(negedge clk);
    bus.S_AXI_AWADDR = 32'h14; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'hCAFEF00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    checks++;
    if (bus.S_AXI_BVALID !== 1'b1) begin
      failures++; $display("FAIL pre-reset bvalid: got %b expected 1", bus.S_AXI_BVALID);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY} !== 4'b0000) begin
      failures++;
      $display("FAIL async reset outputs: got %b expected 0000",
               {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY});
    end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID} !== 4'b1110) begin
      failures++;
      $display("FAIL post-reset readies: got %b expected 1110",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID});
    end
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(32'(i * 4), 0, data, resp, lat, ok, to);
      checks++;
      if (to || data !== exp_mem[i] || resp !== 2'b00) begin
        failures++; $display("FAIL post-reset word %0d: got %h/%b expected 00000000/00", i, data, resp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_same_cycle();
    test_w_first();
    test_out_of_range();
    test_stalls();
    test_concurrent();
    test_random();
    test_reset_mid_resp();
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
